// File: rtl/io_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : io_bus_pkg                                                |
// | Purpose  : Shared types and constants for the io_bus_ctrl slice:     |
// |            FSM state encoding, bus widths, idle read value.          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package io_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  // Value returned on writes, timeouts and out of reset
  localparam logic [DATA_W-1:0] IDLE_RDATA = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STRETCH = 2'd1,
    WAITACK = 2'd2,
    DONE    = 2'd3
  } bus_state_t;

endpackage : io_bus_pkg
`default_nettype wire

// File: rtl/io_bus_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : io_bus_decode                                             |
// | Purpose  : Combinational address decoder. Maps a CPU address onto    |
// |            {hit, slot index} for a window of NUM_SLOTS slots of      |
// |            2^SLOT_BITS bytes starting at BASE_ADDR.                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module io_bus_decode
  import io_bus_pkg::*;
#(
  parameter int                NUM_SLOTS = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'hE600,
  parameter int                SLOT_BITS = 5,
  parameter int                IDX_W     = 3
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  slot_idx
);

  // One extra bit so a window ending exactly at 64K does not wrap
  typedef logic [ADDR_W:0] addr_ext_t;
  typedef logic [IDX_W-1:0] idx_t;

  localparam addr_ext_t WIN_BASE = addr_ext_t'(BASE_ADDR);
  localparam addr_ext_t WIN_END  = addr_ext_t'(BASE_ADDR) + addr_ext_t'(NUM_SLOTS << SLOT_BITS);

  assign hit      = ({1'b0, addr} >= WIN_BASE) && ({1'b0, addr} < WIN_END);
  // Window is aligned, so the offset's upper bits are the slot number
  assign slot_idx = idx_t'((addr - BASE_ADDR) >> SLOT_BITS);

endmodule : io_bus_decode
`default_nettype wire

// File: rtl/io_bus_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : io_bus_ctrl                                               |
// | Purpose  : CPU-to-peripheral bus controller. Decodes a slot window,  |
// |            stretches each access by a per-target wait count,         |
// |            optionally waits for a per-slot ack with timeout, and     |
// |            returns registered read data with a one-cycle ready.      |
// | Options  : IO_BUS_ERR_LOG_EN adds err_addr/err_clr error logging.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module io_bus_ctrl
  import io_bus_pkg::*;
#(
  parameter int                   NUM_SLOTS   = 8,
  parameter logic [ADDR_W-1:0]    BASE_ADDR   = 16'hE600,
  parameter int                   SLOT_BITS   = 5,
  parameter logic [4*NUM_SLOTS-1:0] WAIT_STATES = {NUM_SLOTS{4'd0}},
  parameter logic [NUM_SLOTS-1:0] ACK_USE     = {NUM_SLOTS{1'b0}},
  parameter int                   MEM_WAIT    = 0,
  parameter logic [7:0]           TIMEOUT     = 8'd64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req,
  input  logic [ADDR_W-1:0]             addr,
  input  logic                          rw,
  input  logic [DATA_W-1:0]             wdata,
  output logic [DATA_W-1:0]             rdata,
  output logic                          ready,
  output logic                          bus_err,
  output logic [NUM_SLOTS-1:0]          slot_cs,
  output logic [SLOT_BITS-1:0]          slot_addr,
  output logic                          slot_rw,
  output logic [DATA_W-1:0]             slot_wdata,
  input  logic [DATA_W*NUM_SLOTS-1:0]   slot_rdata,
  input  logic [NUM_SLOTS-1:0]          slot_ack,
`ifdef IO_BUS_ERR_LOG_EN
  input  logic                          err_clr,
  output logic [ADDR_W-1:0]             err_addr,
`endif
  output logic                          mem_cs,
  input  logic [DATA_W-1:0]             mem_rdata
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  bus_state_t               state;
  logic [3:0]               cnt;
  logic [7:0]               tcnt;
  logic                     tgt_hit;
  logic [IDX_W-1:0]         tgt_idx;

  logic                     dec_hit;
  logic [IDX_W-1:0]         dec_idx;
  logic [3:0]               dec_wait;
  logic [NUM_SLOTS-1:0]     dec_onehot;
  logic [DATA_W-1:0]        tgt_rdata;
  logic                     tgt_ack;
  logic                     tgt_ack_use;

`ifdef IO_BUS_ERR_LOG_EN
  logic [ADDR_W-1:0]        acc_addr;
`endif

  io_bus_decode #(
    .NUM_SLOTS (NUM_SLOTS),
    .BASE_ADDR (BASE_ADDR),
    .SLOT_BITS (SLOT_BITS),
    .IDX_W     (IDX_W)
  ) u_decode (
    .addr     (addr),
    .hit      (dec_hit),
    .slot_idx (dec_idx)
  );

  // Per-request selections: wait count and chip-select pattern of the addressed target
  always_comb begin
    dec_wait   = dec_hit ? WAIT_STATES[{dec_idx, 2'b00} +: 4] : 4'(MEM_WAIT);
    dec_onehot = '0;
    if (dec_hit) dec_onehot[dec_idx] = 1'b1;
  end

  // Per-access selections driven from the latched target
  assign tgt_rdata   = tgt_hit ? slot_rdata[{tgt_idx, 3'b000} +: DATA_W] : mem_rdata;
  assign tgt_ack     = slot_ack[tgt_idx];
  assign tgt_ack_use = tgt_hit & ACK_USE[tgt_idx];

  // Access sequencer: latch request, stretch, optional ack wait, one-cycle ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      tcnt       <= '0;
      tgt_hit    <= 1'b0;
      tgt_idx    <= '0;
      slot_cs    <= '0;
      mem_cs     <= 1'b0;
      ready      <= 1'b0;
      bus_err    <= 1'b0;
      rdata      <= IDLE_RDATA;
      slot_addr  <= '0;
      slot_rw    <= 1'b0;
      slot_wdata <= '0;
`ifdef IO_BUS_ERR_LOG_EN
      acc_addr   <= '0;
      err_addr   <= '0;
`endif
    end else begin
`ifdef IO_BUS_ERR_LOG_EN
      // A clear in the same cycle as a new timeout is overridden further down
      if (err_clr) begin
        bus_err  <= 1'b0;
        err_addr <= '0;
      end
`endif
      case (state)
        IDLE: begin
          if (req) begin
            tgt_hit    <= dec_hit;
            tgt_idx    <= dec_idx;
            cnt        <= dec_wait;
            slot_addr  <= addr[SLOT_BITS-1:0];
            slot_rw    <= rw;
            slot_wdata <= wdata;
            slot_cs    <= dec_onehot;
            mem_cs     <= ~dec_hit;
`ifdef IO_BUS_ERR_LOG_EN
            acc_addr   <= addr;
`endif
            state      <= STRETCH;
          end
        end

        STRETCH: begin
          if (cnt == 4'd0) begin
            if (tgt_ack_use) begin
              tcnt  <= TIMEOUT;
              state <= WAITACK;
            end else begin
              rdata   <= slot_rw ? tgt_rdata : IDLE_RDATA;
              slot_cs <= '0;
              mem_cs  <= 1'b0;
              ready   <= 1'b1;
              state   <= DONE;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        WAITACK: begin
          // Ack is checked first so an ack on the final cycle still wins
          if (tgt_ack) begin
            rdata   <= slot_rw ? tgt_rdata : IDLE_RDATA;
            slot_cs <= '0;
            ready   <= 1'b1;
            state   <= DONE;
          end else if (tcnt == 8'd1) begin
            rdata   <= IDLE_RDATA;
            bus_err <= 1'b1;
`ifdef IO_BUS_ERR_LOG_EN
            if (!bus_err || err_clr) err_addr <= acc_addr;
`endif
            slot_cs <= '0;
            ready   <= 1'b1;
            state   <= DONE;
          end else begin
            tcnt <= tcnt - 8'd1;
          end
        end

        DONE: begin
          ready <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule : io_bus_ctrl
`default_nettype wire

// File: tb/tb_io_bus_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_io_bus_ctrl                                            |
// | Purpose  : Self-checking bench for io_bus_ctrl. Directed scenarios   |
// |            plus randomized accesses against a timing/data model.     |
// | Options  : IO_BUS_ERR_LOG_EN also exercises err_addr/err_clr.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_io_bus_ctrl;

  localparam int NS   = 8;
  localparam int BASE = 'hE600;
  localparam int SPAN = 32;
  localparam int MEMW = 2;
  localparam int TO   = 6;

  // Configuration of the instance below, written out per slot
  int ws_tab  [NS] = '{0, 2, 0, 1, 0, 0, 3, 0};
  bit ack_tab [NS] = '{0, 0, 1, 0, 0, 0, 0, 1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [15:0] addr = '0;
  logic        rw = 1'b0;
  logic [7:0]  wdata = '0;
  logic [7:0]  rdata;
  logic        ready;
  logic        bus_err;
  logic [7:0]  slot_cs;
  logic [4:0]  slot_addr;
  logic        slot_rw;
  logic [7:0]  slot_wdata;
  logic [63:0] slot_rdata = '0;
  logic [7:0]  slot_ack = '0;
  logic        mem_cs;
  logic [7:0]  mem_rdata = '0;
`ifdef IO_BUS_ERR_LOG_EN
  logic        err_clr = 1'b0;
  logic [15:0] err_addr;
  logic [15:0] m_err_addr = '0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit sticky   = 1'b0;

  always #5 clk = ~clk;

  io_bus_ctrl #(
    .NUM_SLOTS   (8),
    .BASE_ADDR   (16'hE600),
    .SLOT_BITS   (5),
    .WAIT_STATES (32'h0300_1020),
    .ACK_USE     (8'b1000_0100),
    .MEM_WAIT    (2),
    .TIMEOUT     (8'd6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .addr       (addr),
    .rw         (rw),
    .wdata      (wdata),
    .rdata      (rdata),
    .ready      (ready),
    .bus_err    (bus_err),
    .slot_cs    (slot_cs),
    .slot_addr  (slot_addr),
    .slot_rw    (slot_rw),
    .slot_wdata (slot_wdata),
    .slot_rdata (slot_rdata),
    .slot_ack   (slot_ack),
`ifdef IO_BUS_ERR_LOG_EN
    .err_clr    (err_clr),
    .err_addr   (err_addr),
`endif
    .mem_cs     (mem_cs),
    .mem_rdata  (mem_rdata)
  );

  task automatic randomize_buses();
    slot_rdata = {$urandom, $urandom};
    mem_rdata  = 8'($urandom);
  endtask

  // One access. ack_k: WAITACK cycle in which the ack first appears (0 = never).
  // lat counts cycles from the req cycle (=1) to the ready cycle inclusive.
  task automatic do_access(input logic [15:0] a, input logic r, input logic [7:0] wd,
                           input int ack_k, output int lat, output int csc);
    bit hit, ack, err, got;
    int slot, w, kk, cs_exp, c;
    logic [7:0] exp_rd, exp_cs;
    logic exp_mem;

    hit     = (int'(a) >= BASE) && (int'(a) < BASE + NS * SPAN);
    slot    = hit ? (int'(a) - BASE) / SPAN : 0;
    w       = hit ? ws_tab[slot] : MEMW;
    ack     = hit && ack_tab[slot];
    err     = ack && !(ack_k >= 1 && ack_k <= TO);
    kk      = !ack ? 0 : (err ? TO : ack_k);
    cs_exp  = w + 1 + kk;
    exp_cs  = hit ? 8'(1 << slot) : 8'h00;
    exp_mem = !hit;
    exp_rd  = (!r || err) ? 8'hFF : (hit ? slot_rdata[slot*8 +: 8] : mem_rdata);

    @(posedge clk); #1;
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_pulse_width: got %b want 0", ready);
    end
    req = 1'b1; addr = a; rw = r; wdata = wd;
    @(posedge clk); #1;
    req = 1'b0; addr = 16'($urandom); rw = 1'($urandom); wdata = 8'($urandom);

    c = 1; csc = 0; got = 1'b0; lat = 0;
    while (!got && c <= 64) begin
      slot_ack = 8'($urandom) & (ack ? ~exp_cs : 8'hFF);
      if (ack && ack_k >= 1 && c >= w + 1 + ack_k) slot_ack = slot_ack | exp_cs;
      if (slot_cs !== 8'h00 || mem_cs !== 1'b0) begin
        csc++;
        n_checks++;
        if (slot_cs !== exp_cs || mem_cs !== exp_mem) begin
          n_fail++;
          $display("FAIL cs_select a=%h: got cs=%h mem=%b want cs=%h mem=%b", a, slot_cs, mem_cs, exp_cs, exp_mem);
        end
        n_checks++;
        if (slot_rw !== r || slot_addr !== a[4:0] || slot_wdata !== wd) begin
          n_fail++;
          $display("FAIL latched a=%h: got rw=%b off=%h wd=%h want rw=%b off=%h wd=%h",
                   a, slot_rw, slot_addr, slot_wdata, r, a[4:0], wd);
        end
      end
      if (ready === 1'b1) begin
        got = 1'b1;
        lat = c + 1;
      end else begin
        @(posedge clk); #1;
        c++;
      end
    end
    slot_ack = '0;

    n_checks++;
    if (!got) begin
      n_fail++; $display("FAIL ready_timeout a=%h: no ready within 64 cycles", a);
      return;
    end
`ifdef IO_BUS_ERR_LOG_EN
    if (err && !sticky) m_err_addr = a;
`endif
    if (err) sticky = 1'b1;

    n_checks++;
    if (csc != cs_exp) begin
      n_fail++; $display("FAIL cs_cycles a=%h: got %0d want %0d", a, csc, cs_exp);
    end
    n_checks++;
    if (lat != cs_exp + 2) begin
      n_fail++; $display("FAIL latency a=%h: got %0d want %0d", a, lat, cs_exp + 2);
    end
    n_checks++;
    if (rdata !== exp_rd) begin
      n_fail++; $display("FAIL rdata a=%h: got %h want %h", a, rdata, exp_rd);
    end
    n_checks++;
    if (bus_err !== sticky) begin
      n_fail++; $display("FAIL bus_err a=%h: got %b want %b", a, bus_err, sticky);
    end
    n_checks++;
    if (slot_cs !== 8'h00 || mem_cs !== 1'b0) begin
      n_fail++; $display("FAIL cs_in_done a=%h: got cs=%h mem=%b want 0", a, slot_cs, mem_cs);
    end
`ifdef IO_BUS_ERR_LOG_EN
    n_checks++;
    if (err_addr !== m_err_addr) begin
      n_fail++; $display("FAIL err_addr a=%h: got %h want %h", a, err_addr, m_err_addr);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (slot_cs !== 8'h00 || mem_cs !== 1'b0 || ready !== 1'b0 || bus_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got cs=%h mem=%b rdy=%b err=%b want all 0", slot_cs, mem_cs, ready, bus_err);
    end
    n_checks++;
    if (rdata !== 8'hFF || slot_addr !== 5'h00 || slot_rw !== 1'b0 || slot_wdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data: got rd=%h off=%h rw=%b wd=%h want FF 00 0 00", rdata, slot_addr, slot_rw, slot_wdata);
    end
    rst = 1'b0;
    sticky = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (slot_cs !== 8'h00 || mem_cs !== 1'b0 || ready !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got cs=%h mem=%b rdy=%b", slot_cs, mem_cs, ready);
    end
  endtask

  task automatic test_slot_read();
    int lat, csc;
    randomize_buses();
    slot_rdata[47:40] = 8'h5A;
    do_access(16'hE6B0, 1'b1, 8'h00, 0, lat, csc);
    n_checks++;
    if (lat != 3 || csc != 1 || rdata !== 8'h5A) begin
      n_fail++; $display("FAIL slot5_read: got lat=%0d cs=%0d rd=%h want 3 1 5A", lat, csc, rdata);
    end
  endtask

  task automatic test_slot_write();
    int lat, csc;
    randomize_buses();
    do_access(16'hE6D9, 1'b0, 8'h3C, 0, lat, csc);
    n_checks++;
    if (lat != 6 || csc != 4 || rdata !== 8'hFF) begin
      n_fail++; $display("FAIL slot6_write: got lat=%0d cs=%0d rd=%h want 6 4 FF", lat, csc, rdata);
    end
    n_checks++;
    if (slot_addr !== 5'h19 || slot_wdata !== 8'h3C || slot_rw !== 1'b0) begin
      n_fail++; $display("FAIL slot6_latch: got off=%h wd=%h rw=%b want 19 3C 0", slot_addr, slot_wdata, slot_rw);
    end
  endtask

  task automatic test_mem_read();
    int lat, csc;
    randomize_buses();
    mem_rdata = 8'hA7;
    do_access(16'h0123, 1'b1, 8'h00, 0, lat, csc);
    n_checks++;
    if (csc != 3 || rdata !== 8'hA7) begin
      n_fail++; $display("FAIL mem_read: got cs=%0d rd=%h want 3 A7", csc, rdata);
    end
  endtask

  task automatic test_ack();
    int lat, csc;
    logic [7:0] d;
    randomize_buses();
    slot_rdata[23:16] = 8'h11;
    do_access(16'hE640, 1'b1, 8'h00, 5, lat, csc);
    n_checks++;
    if (rdata !== 8'h11 || bus_err !== 1'b0 || csc != 6) begin
      n_fail++; $display("FAIL ack_read: got rd=%h err=%b cs=%0d want 11 0 6", rdata, bus_err, csc);
    end
    // Ack arriving on the last allowed cycle must win over the timeout
    randomize_buses();
    d = slot_rdata[23:16];
    do_access(16'hE640, 1'b1, 8'h00, TO, lat, csc);
    n_checks++;
    if (rdata !== d || bus_err !== 1'b0 || csc != 1 + TO) begin
      n_fail++; $display("FAIL ack_at_expiry: got rd=%h err=%b cs=%0d want %h 0 %0d", rdata, bus_err, csc, d, 1 + TO);
    end
  endtask

  task automatic test_window_edges();
    int lat, csc;
    randomize_buses();
    do_access(16'hE5FF, 1'b1, 8'h00, 0, lat, csc);
    n_checks++;
    if (csc != 3) begin n_fail++; $display("FAIL edge_below: got cs=%0d want 3", csc); end
    do_access(16'hE600, 1'b1, 8'h00, 0, lat, csc);
    n_checks++;
    if (csc != 1) begin n_fail++; $display("FAIL edge_first: got cs=%0d want 1", csc); end
    do_access(16'hE6FF, 1'b0, 8'h77, 1, lat, csc);
    n_checks++;
    if (csc != 2) begin n_fail++; $display("FAIL edge_last: got cs=%0d want 2", csc); end
    do_access(16'hE700, 1'b1, 8'h00, 0, lat, csc);
    n_checks++;
    if (csc != 3) begin n_fail++; $display("FAIL edge_above: got cs=%0d want 3", csc); end
  endtask

  task automatic test_timeout();
    int lat, csc;
    randomize_buses();
    do_access(16'hE640, 1'b1, 8'h00, 0, lat, csc);
    n_checks++;
    if (csc - 1 != TO || rdata !== 8'hFF || bus_err !== 1'b1) begin
      n_fail++; $display("FAIL timeout: got waitack=%0d rd=%h err=%b want %0d FF 1", csc - 1, rdata, bus_err, TO);
    end
`ifdef IO_BUS_ERR_LOG_EN
    n_checks++;
    if (err_addr !== 16'hE640) begin
      n_fail++; $display("FAIL err_addr_first: got %h want E640", err_addr);
    end
    do_access(16'hE6E0, 1'b1, 8'h00, 0, lat, csc);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    sticky = 1'b0;
    m_err_addr = '0;
    n_checks++;
    if (bus_err !== 1'b0 || err_addr !== 16'h0000) begin
      n_fail++; $display("FAIL err_clr: got err=%b addr=%h want 0 0000", bus_err, err_addr);
    end
`endif
  endtask

  task automatic test_reset_mid_access();
    int lat, csc;
    @(posedge clk); #1;
    req = 1'b1; addr = 16'hE640; rw = 1'b1; wdata = 8'h00;
    slot_ack = '0;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (slot_cs !== 8'h04) begin
      n_fail++; $display("FAIL pre_reset_cs: got %h want 04", slot_cs);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (slot_cs !== 8'h00 || mem_cs !== 1'b0 || ready !== 1'b0 || bus_err !== 1'b0 || rdata !== 8'hFF) begin
      n_fail++;
      $display("FAIL async_abort: got cs=%h mem=%b rdy=%b err=%b rd=%h", slot_cs, mem_cs, ready, bus_err, rdata);
    end
    sticky = 1'b0;
`ifdef IO_BUS_ERR_LOG_EN
    m_err_addr = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (ready !== 1'b0) begin
        n_fail++; $display("FAIL no_ready_after_abort: cycle %0d got ready=1", i);
      end
    end
    randomize_buses();
    do_access(16'hE600, 1'b1, 8'h00, 0, lat, csc);
    n_checks++;
    if (lat != 3 || rdata !== slot_rdata[7:0]) begin
      n_fail++; $display("FAIL post_reset_access: got lat=%0d rd=%h want 3 %h", lat, rdata, slot_rdata[7:0]);
    end
  endtask

  task automatic test_random();
    int lat, csc;
    logic [15:0] a;
    for (int n = 0; n < 60; n++) begin
      randomize_buses();
      if ($urandom_range(0, 2) != 0) a = 16'(BASE + $urandom_range(0, NS * SPAN - 1));
      else                           a = 16'($urandom);
      do_access(a, 1'($urandom), 8'($urandom), $urandom_range(0, TO + 2), lat, csc);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_slot_read();
    test_slot_write();
    test_mem_read();
    test_ack();
    test_window_edges();
    test_timeout();
    test_reset_mid_access();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_io_bus_ctrl
`default_nettype wire
